twobutton_led_ctrl: RTL

Debounced two-button front end driving the two board LEDs as per-button mode indicators. Each raw push-button input is synchronised and debounced, and its press edge is turned into a single-cycle pulse. Each pulse advances that button's LED through OFF → ON → BLINK → OFF. The block sits between the board's bluebtn/redbtn pins and the led[0:1] pins, replacing the direct pin-to-pin wiring.

---
 rtl/twobutton_led_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/twobutton_led_ctrl.sv
// rtl/twobutton_led_ctrl.sv - debounced two-button front end cycling each LED through OFF/ON/BLINK
module twobutton_led_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Buttons are active-low, so "released" (1) is the idle value everywhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      press_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      press_q       <= stable_prev_q & ~stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module twobutton_led_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bluebtn,
  input  logic       redbtn,
  output logic [0:1] led,
  output logic       blue_press,
  output logic       red_press
);
  localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10
  } mode_e;

  mode_e         blue_mode_q;
  mode_e         red_mode_q;
  logic [PW-1:0] pre_q;
  logic          blink_phase_q;
  logic [0:1]    led_q;
  logic          both_press;

  twobutton_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_blue (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bluebtn),
    .press_o (blue_press)
  );

  twobutton_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_red (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (redbtn),
    .press_o (red_press)
  );

  assign both_press = blue_press & red_press;

  function automatic mode_e next_mode(input mode_e m, input logic press, input logic both);
    next_mode = MODE_OFF;
    case (m)
      MODE_OFF:   next_mode = press ? MODE_ON    : MODE_OFF;
      MODE_ON:    next_mode = press ? MODE_BLINK : MODE_ON;
      MODE_BLINK: next_mode = press ? MODE_OFF   : MODE_BLINK;
      default:    next_mode = MODE_OFF;
    endcase
    if (both) next_mode = MODE_OFF;
  endfunction

  function automatic logic led_bit(input mode_e m, input logic phase);
    led_bit = 1'b0;
    case (m)
      MODE_ON:    led_bit = 1'b1;
      MODE_BLINK: led_bit = phase;
      default:    led_bit = 1'b0;
    endcase
  endfunction

  // The blink phase is free-running and shared, so entering BLINK picks up wherever it is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q         <= '0;
      blink_phase_q <= 1'b0;
      blue_mode_q   <= MODE_OFF;
      red_mode_q    <= MODE_OFF;
      led_q         <= 2'b00;
    end else begin
      if (pre_q == PRE_MAX) begin
        pre_q         <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      blue_mode_q <= next_mode(blue_mode_q, blue_press, both_press);
      red_mode_q  <= next_mode(red_mode_q, red_press, both_press);
      led_q[0]    <= led_bit(blue_mode_q, blink_phase_q);
      led_q[1]    <= led_bit(red_mode_q, blink_phase_q);
    end
  end

  assign led = led_q;
endmodule
